// File: rtl/hopfield_engine.sv
// +-----------------------------------------------------------------------------
// | Module   : hopfield_engine
// | Purpose  : Hopfield network engine. It recalls patterns by updating neurons
// |            asynchronously, one at a time, and applies Hebbian learning to an
// |            on-chip N*N weight store.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module hopfield_engine #(
  parameter int N     = 25,
  parameter int WW    = 8,
  parameter int MAXIT = 16,
  parameter int AW    = WW + $clog2(N) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [N-1:0]            pattern_in,
  input  logic                    wt_we,
  input  logic [$clog2(N*N)-1:0]  wt_addr,
  input  logic [WW-1:0]           wt_data,
  output logic [N-1:0]            state_out,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [7:0]              iter_count
);

  localparam int KW  = $clog2(N);
  localparam int ADW = $clog2(N*N);
  localparam int NN  = N * N;
  localparam logic signed [WW:0] C_WMAX = (WW+1)'((1 << (WW-1)) - 1);

  typedef enum logic [2:0] {IDLE, ACC, UPD, CHK, LEARN, CLEAR, FIN} state_t;

  state_t                fsm_q, fsm_d;
  logic [KW-1:0]         k_q, k_d, m_q, m_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [7:0]            iter_q, iter_d;
  logic                  chg_q, chg_d;
  logic                  conv_q, conv_d;
  logic [N-1:0]          nst_q, nst_d;
  logic signed [WW-1:0]  mem_q [NN];

  logic                  mem_we;
  logic [ADW-1:0]        mem_waddr;
  logic signed [WW-1:0]  mem_wdata;

  logic [ADW-1:0]        w_rd_addr;
  logic signed [WW-1:0]  w_rd_data;
  logic signed [AW-1:0]  w_ext;
  logic signed [WW:0]    w_step;
  logic signed [WW:0]    w_sum;
  logic signed [WW-1:0]  w_learn;
  logic                  w_k_last, w_m_last;

  assign w_rd_addr = ADW'(32'(k_q) * 32'(N) + 32'(m_q));
  assign w_rd_data = mem_q[w_rd_addr];
  assign w_ext     = AW'(w_rd_data);
  assign w_k_last  = (k_q == KW'(N-1));
  assign w_m_last  = (m_q == KW'(N-1));

  // Hebbian step computed one bit wider so saturation can be detected before truncation
  always_comb begin
    w_step = (nst_q[k_q] == nst_q[m_q]) ? (WW+1)'(1) : -(WW+1)'(1);
    w_sum  = (WW+1)'(w_rd_data) + w_step;
    if (w_sum > C_WMAX)
      w_learn = WW'(C_WMAX);
    else if (w_sum < -C_WMAX)
      w_learn = WW'(-C_WMAX);
    else
      w_learn = WW'(w_sum);
  end

  always_comb begin
    fsm_d     = fsm_q;
    k_d       = k_q;
    m_d       = m_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    chg_d     = chg_q;
    conv_d    = conv_q;
    nst_d     = nst_q;
    mem_we    = 1'b0;
    mem_waddr = w_rd_addr;
    mem_wdata = '0;
    case (fsm_q)
      IDLE: begin
        if (wt_we && (32'(wt_addr) < NN)) begin
          mem_we    = 1'b1;
          mem_waddr = wt_addr;
          mem_wdata = wt_data;
        end
        if (start) begin
          k_d    = '0;
          m_d    = '0;
          acc_d  = '0;
          iter_d = '0;
          chg_d  = 1'b0;
          conv_d = 1'b0;
          case (op)
            2'b00: begin nst_d = pattern_in; fsm_d = ACC;   end
            2'b01: begin nst_d = pattern_in; fsm_d = LEARN; end
            2'b10: begin nst_d = pattern_in; fsm_d = CLEAR; end
            default: fsm_d = FIN;
          endcase
        end
      end
      ACC: begin
        acc_d = nst_q[m_q] ? (acc_q + w_ext) : (acc_q - w_ext);
        if (w_m_last) begin
          m_d   = '0;
          fsm_d = UPD;
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      UPD: begin
        // A zero field leaves the neuron as it is
        if ((acc_q > 0) && !nst_q[k_q]) begin
          nst_d[k_q] = 1'b1;
          chg_d      = 1'b1;
        end else if ((acc_q < 0) && nst_q[k_q]) begin
          nst_d[k_q] = 1'b0;
          chg_d      = 1'b1;
        end
        acc_d = '0;
        if (w_k_last) begin
          k_d    = '0;
          iter_d = iter_q + 8'd1;
          fsm_d  = CHK;
        end else begin
          k_d   = k_q + 1'b1;
          fsm_d = ACC;
        end
      end
      CHK: begin
        if (!chg_q) begin
          conv_d = 1'b1;
          fsm_d  = FIN;
        end else if (iter_q == 8'(MAXIT)) begin
          conv_d = 1'b0;
          fsm_d  = FIN;
        end else begin
          chg_d = 1'b0;
          k_d   = '0;
          fsm_d = ACC;
        end
      end
      LEARN, CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = ((fsm_q == CLEAR) || (k_q == m_q)) ? '0 : w_learn;
        if (w_m_last) begin
          m_d = '0;
          if (w_k_last) begin
            k_d   = '0;
            fsm_d = FIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      FIN:     fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      k_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      iter_q <= '0;
      chg_q  <= 1'b0;
      conv_q <= 1'b0;
      nst_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      k_q    <= k_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
      iter_q <= iter_d;
      chg_q  <= chg_d;
      conv_q <= conv_d;
      nst_q  <= nst_d;
    end
  end

  // Weights survive reset; only the clear operation wipes them
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign state_out  = nst_q;
  assign busy       = (fsm_q != IDLE);
  assign done       = (fsm_q == FIN);
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_hopfield_engine.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_hopfield_engine
// | Purpose  : Self-checking bench for hopfield_engine, scored against a
// |            behavioural network model.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_hopfield_engine;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int MAXIT = 3;
  localparam int ADW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [N-1:0]    pattern_in = '0;
  logic            wt_we = 1'b0;
  logic [ADW-1:0]  wt_addr = '0;
  logic [WW-1:0]   wt_data = '0;
  logic [N-1:0]    state_out;
  logic            busy, done, converged;
  logic [7:0]      iter_count;

  hopfield_engine #(.N(N), .WW(WW), .MAXIT(MAXIT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .pattern_in(pattern_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .state_out(state_out), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] st;
    logic         conv;
    logic [7:0]   it;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   wm[N*N];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void model_learn(input logic [N-1:0] p);
    for (int k = 0; k < N; k++)
      for (int m = 0; m < N; m++) begin
        if (k == m) wm[k*N+m] = 0;
        else begin
          wm[k*N+m] = wm[k*N+m] + ((p[k] == p[m]) ? 1 : -1);
          if (wm[k*N+m] > 7)  wm[k*N+m] = 7;
          if (wm[k*N+m] < -7) wm[k*N+m] = -7;
        end
      end
  endfunction

  function automatic exp_t model_recall(input logic [N-1:0] seed);
    exp_t e;
    bit   chg;
    int   acc;
    e.st = seed; e.conv = 1'b0; e.it = 8'd0;
    for (int s = 0; s < MAXIT; s++) begin
      chg = 1'b0;
      for (int k = 0; k < N; k++) begin
        acc = 0;
        for (int m = 0; m < N; m++)
          acc = acc + (e.st[m] ? wm[k*N+m] : -wm[k*N+m]);
        if (acc > 0 && !e.st[k])     begin e.st[k] = 1'b1; chg = 1'b1; end
        else if (acc < 0 && e.st[k]) begin e.st[k] = 1'b0; chg = 1'b1; end
      end
      e.it = e.it + 8'd1;
      if (!chg) begin e.conv = 1'b1; break; end
    end
    e.lat = int'(e.it) * (N*(N+1)+1) + 1;
    return e;
  endfunction

  // Launches one operation and reports when done appeared; poke fires a
  // start+weight write while the engine is busy.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] p, input bit wr,
                        input logic [ADW-1:0] wa, input logic [WW-1:0] wd, input bit poke,
                        output int cyc, output bit first_busy, output bit pulse_once);
    @(negedge clk);
    start = 1'b1; op = o; pattern_in = p; wt_we = wr; wt_addr = wa; wt_data = wd;
    @(negedge clk);
    start = 1'b0; wt_we = 1'b0; op = 2'b00;
    cyc = 1;
    first_busy = busy;
    while (!done && cyc < 400) begin
      if (poke && cyc == 5) begin
        start = 1'b1; op = 2'b01; wt_we = 1'b1; wt_addr = '0; wt_data = 4'h7;
      end
      @(negedge clk);
      start = 1'b0; wt_we = 1'b0;
      cyc++;
    end
    if (!done) cyc = -1;
    @(negedge clk);
    pulse_once = !done && !busy;
  endtask

  task automatic wr_weight(input int a, input int v);
    @(negedge clk);
    wt_we = 1'b1; wt_addr = ADW'(a); wt_data = WW'(v);
    @(negedge clk);
    wt_we = 1'b0;
    wm[a] = v;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (state_out !== '0) $display("FAIL reset_state got %b exp 0000", state_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_total++; if (converged !== 1'b0) $display("FAIL reset_conv got %b exp 0", converged); else n_pass++;
    n_total++; if (iter_count !== 8'd0) $display("FAIL reset_iter got %0d exp 0", iter_count); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_recall_case(input string name, input logic [N-1:0] seed, input bit wr,
                                  input int wa, input int wv, input bit poke);
    exp_t e;
    int   cyc;
    bit   fb, po;
    if (wr) wm[wa] = wv;
    sb.push_back(model_recall(seed));
    run_op(2'b00, seed, wr, ADW'(wa), WW'(wv), poke, cyc, fb, po);
    e = sb.pop_front();
    n_total++; if (cyc != e.lat) $display("FAIL %s latency got %0d exp %0d", name, cyc, e.lat); else n_pass++;
    n_total++; if (state_out !== e.st) $display("FAIL %s state got %b exp %b", name, state_out, e.st); else n_pass++;
    n_total++; if (converged !== e.conv) $display("FAIL %s conv got %b exp %b", name, converged, e.conv); else n_pass++;
    n_total++; if (iter_count !== e.it) $display("FAIL %s iter got %0d exp %0d", name, iter_count, e.it); else n_pass++;
    n_total++; if (fb !== 1'b1) $display("FAIL %s busy_after_start got %b exp 1", name, fb); else n_pass++;
    n_total++; if (po !== 1'b1) $display("FAIL %s single_done got %b exp 1", name, po); else n_pass++;
  endtask

  task automatic test_learn_op(input string name, input logic [1:0] o, input logic [N-1:0] p);
    exp_t e;
    int   cyc;
    bit   fb, po;
    e.st = (o == 2'b11) ? state_out : p;
    e.conv = 1'b0; e.it = 8'd0;
    e.lat = (o == 2'b11) ? 1 : N*N + 1;
    if (o == 2'b01) model_learn(p);
    if (o == 2'b10) for (int i = 0; i < N*N; i++) wm[i] = 0;
    sb.push_back(e);
    run_op(o, p, 1'b0, '0, '0, 1'b0, cyc, fb, po);
    e = sb.pop_front();
    n_total++; if (cyc != e.lat) $display("FAIL %s latency got %0d exp %0d", name, cyc, e.lat); else n_pass++;
    n_total++; if (state_out !== e.st) $display("FAIL %s state got %b exp %b", name, state_out, e.st); else n_pass++;
    n_total++; if (converged !== 1'b0) $display("FAIL %s conv got %b exp 0", name, converged); else n_pass++;
    n_total++; if (iter_count !== 8'd0) $display("FAIL %s iter got %0d exp 0", name, iter_count); else n_pass++;
    n_total++; if (po !== 1'b1) $display("FAIL %s single_done got %b exp 1", name, po); else n_pass++;
    for (int i = 0; i < N*N; i++) begin
      n_total++;
      if (dut.mem_q[i] !== WW'(wm[i]))
        $display("FAIL %s weight[%0d] got %0d exp %0d", name, i, dut.mem_q[i], wm[i]);
      else n_pass++;
    end
  endtask

  task automatic test_learn;
    test_learn_op("clear", 2'b10, 4'b0000);
    test_learn_op("learn", 2'b01, 4'b1010);
    n_total++; if (dut.mem_q[2] !== 4'sd1) $display("FAIL learn_w02 got %0d exp 1", dut.mem_q[2]); else n_pass++;
    n_total++; if (dut.mem_q[1] !== -4'sd1) $display("FAIL learn_w01 got %0d exp -1", dut.mem_q[1]); else n_pass++;
  endtask

  task automatic test_recall;
    test_recall_case("recall_1000", 4'b1000, 1'b0, 0, 0, 1'b0);
    n_total++; if (state_out !== 4'b1010) $display("FAIL recall_fixed_state got %b exp 1010", state_out); else n_pass++;
    n_total++; if (iter_count !== 8'd2) $display("FAIL recall_fixed_iter got %0d exp 2", iter_count); else n_pass++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 7; i++) test_learn_op("learn_sat", 2'b01, 4'b1010);
    n_total++; if (dut.mem_q[2] !== 4'sd7) $display("FAIL sat_w02 got %0d exp 7", dut.mem_q[2]); else n_pass++;
    n_total++; if (dut.mem_q[1] !== -4'sd7) $display("FAIL sat_w01 got %0d exp -7", dut.mem_q[1]); else n_pass++;
  endtask

  task automatic test_zero_weights;
    test_learn_op("clear2", 2'b10, 4'b0000);
    test_recall_case("zero_w_0110", 4'b0110, 1'b0, 0, 0, 1'b0);
    n_total++; if (state_out !== 4'b0110) $display("FAIL zero_w_fixed_state got %b exp 0110", state_out); else n_pass++;
    n_total++; if (iter_count !== 8'd1) $display("FAIL zero_w_fixed_iter got %0d exp 1", iter_count); else n_pass++;
  endtask

  task automatic test_oscillate;
    wr_weight(0, -1);
    test_recall_case("oscillate", 4'b0000, 1'b0, 0, 0, 1'b0);
    n_total++; if (converged !== 1'b0) $display("FAIL osc_fixed_conv got %b exp 0", converged); else n_pass++;
    n_total++; if (iter_count !== 8'd3) $display("FAIL osc_fixed_iter got %0d exp 3", iter_count); else n_pass++;
  endtask

  task automatic test_coincident;
    test_recall_case("wr_with_start", 4'b0000, 1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    test_recall_case("busy_ignore", 4'b1111, 1'b0, 0, 0, 1'b1);
    n_total++; if (dut.mem_q[0] !== 4'sd1) $display("FAIL busy_wr_ignored got %0d exp 1", dut.mem_q[0]); else n_pass++;
  endtask

  task automatic test_reserved;
    test_learn_op("reserved_op", 2'b11, 4'b0101);
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 2'b00; pattern_in = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (state_out !== '0) $display("FAIL mid_reset_state got %b exp 0000", state_out); else n_pass++;
    n_total++; if (iter_count !== 8'd0) $display("FAIL mid_reset_iter got %0d exp 0", iter_count); else n_pass++;
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_total++; if (ndone != 0) $display("FAIL mid_reset_done got %0d pulses exp 0", ndone); else n_pass++;
    test_recall_case("after_reset", 4'b0101, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_learn;
    test_recall;
    test_saturate;
    test_zero_weights;
    test_oscillate;
    test_coincident;
    test_busy_ignore;
    test_reserved;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hopfield_engine.md
HOPFIELD_ENGINE -- requirements
Module: hopfield_engine

Interface
REQ-001 Parameter N, default 25, neuron count (2..64); state bit k = neuron k.
REQ-002 Parameter WW, default 8, signed weight width (3..16).
REQ-003 Parameter MAXIT, default 16, maximum recall sweeps per start (1..255).
REQ-004 Parameter AW, default WW+$clog2(N)+1, signed accumulator width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request; sampled only in IDLE.
REQ-008 op  input  2  operation at start: 00 recall, 01 learn, 10 clear weights, 11 reserved (no-op).
REQ-009 pattern_in  input  N  recall seed / learn pattern, captured on accepted start.
REQ-010 wt_we, wt_addr, wt_data  input  1 / $clog2(N*N) / WW  direct weight write, address k*N+m.
REQ-011 state_out  output  N  current neuron state, registered.
REQ-012 busy  output  1  high from cycle after accepted start until done.
REQ-013 done  output  1  one-cycle pulse at operation end.
REQ-014 converged  output  1  valid with done for recall; held until next accepted start.
REQ-015 iter_count  output  8  completed recall sweeps, held until next accepted start.

Function
REQ-016 Weight store SHALL be N*N signed WW-bit entries, w[k][m] at k*N+m, one read or write per cycle.
REQ-017 FSM states SHALL be IDLE, ACC, UPD, CHK, LEARN, CLEAR, FIN.
REQ-018 IDLE + start + op=00: latch pattern_in into state, k=0, m=0, acc=0, iter=0, go ACC.
REQ-019 ACC: one cycle per m, acc += state[m] ? w[k][m] : -w[k][m]; after m=N-1 go UPD.
REQ-020 UPD (1 cycle): state[k] <= 1 if acc>0, 0 if acc<0, unchanged if acc==0; record change flag; acc=0.
REQ-021 Updates SHALL be asynchronous (in-place): neuron k+1 uses already-updated state[k].
REQ-022 After UPD with k<N-1: k+1, go ACC; with k=N-1: iter+1, go CHK.
REQ-023 CHK: no bit changed in sweep -> converged=1, FIN; else iter==MAXIT -> converged=0, FIN; else k=0, ACC.
REQ-024 Recall sweep latency SHALL be exactly N*(N+1)+1 cycles including CHK.
REQ-025 op=01 LEARN: one cycle per (k,m), row-major; k!=m: w += (p[k]==p[m]) ? +1 : -1, saturating at +/-(2^(WW-1)-1); k==m: w=0; N*N cycles.
REQ-026 op=10 CLEAR: write 0 to all N*N entries, one per cycle, N*N cycles.
REQ-027 op=11: go directly to FIN; done pulses, state unchanged.
REQ-028 FIN (1 cycle): done=1, busy=0 next cycle, return IDLE; learn/clear leave converged=0, state_out=captured pattern.
REQ-029 start while busy SHALL be ignored; wt_we while busy SHALL be ignored.
REQ-030 wt_we in IDLE SHALL write wt_data to wt_addr next edge; wt_addr >= N*N ignored.
REQ-031 Accumulator SHALL not overflow: AW sized for N*(2^(WW-1)) magnitude.
REQ-032 start coincident with wt_we in IDLE: write takes effect, start accepted, op uses written value.

Reset
REQ-033 rst=0 at clock edge SHALL force IDLE, state_out=0, busy=0, done=0, converged=0, iter_count=0, counters 0.
REQ-034 Reset SHALL not clear weight store; clear only via op=10.
REQ-035 Reset mid-operation SHALL abort immediately; no done pulse; partial weight updates retained.

Verification
REQ-036 N=4,WW=4: clear, learn 1010 -> w[0][2]=+1, w[0][1]=-1, diagonal 0, done after 16+1 cycles.
REQ-037 After REQ-036, recall seed 1000 -> state_out=1010, converged=1, iter_count=2, done pulse once.
REQ-038 Learn 1010 eight times, WW=4 -> off-diagonal saturate at +7/-7, no wrap.
REQ-039 All-zero weights, recall 0110 -> acc==0 always, state unchanged 0110, converged=1, iter_count=1.
REQ-040 Preload weights forming 2-cycle oscillation, MAXIT=3 -> done with converged=0, iter_count=3.
REQ-041 rst=0 during ACC of sweep 1 -> next cycle busy=0, state_out=0, no done; start again ignored-free, runs normally.
